// File: rtl/ps_tap_step_ctrl_if.sv
// Tap-step controller bus: target request in, tap select and status out.
// Master drives the request side, slave is the controller.
interface ps_tap_step_ctrl_if #(
    parameter int NTAPS = 16,
    parameter int TAPW  = 4
);
    logic [TAPW-1:0]  targetTap;
    logic             load;
    logic             freeze;
    logic [TAPW-1:0]  tapSel;
    logic [NTAPS-1:0] tapOneHot;
    logic             busy;
    logic             done;

    modport master (
        output targetTap, load, freeze,
        input  tapSel, tapOneHot, busy, done
    );

    modport slave (
        input  targetTap, load, freeze,
        output tapSel, tapOneHot, busy, done
    );
endinterface

// File: rtl/ps_tap_step_ctrl.sv
// Phase-shifter tap walker: moves the delay-line tap select one step at a
// time along the shortest circular path, holding a settle interval per step.
module ps_tap_step_ctrl #(
    parameter int NTAPS  = 16,
    parameter int TAPW   = 4,
    parameter int SETTLE = 8
) (
    input logic clk40,
    input logic rstn,
    ps_tap_step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        SETL = 2'd2
    } state_t;

    localparam logic [TAPW-1:0] HALF     = TAPW'(NTAPS / 2);
    localparam logic [7:0]      CNT_LOAD = 8'(SETTLE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TAPW-1:0]  r_target;
    logic [TAPW-1:0]  r_tap;
    logic [NTAPS-1:0] r_onehot;
    logic [7:0]       r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [TAPW-1:0]  w_tgt_nxt;
    logic [TAPW-1:0]  w_diff;
    logic             w_up;
    logic [TAPW-1:0]  w_tap_nxt;
    logic [7:0]       w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [NTAPS-1:0] w_onehot_nxt;

    // Target as it will be after this edge; a same-cycle load takes effect.
    always_comb begin
        w_tgt_nxt = bus.load ? bus.targetTap : r_target;
        w_diff    = r_target - r_tap;
        w_up      = (w_diff <= HALF);
    end

    // State register.
    always_ff @(posedge clk40 or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decision: IDLE waits for a pending target, SETL for count 0.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (r_target != r_tap && !bus.freeze)
                    w_state_nxt = STEP;
            end
            STEP: begin
                w_state_nxt = (w_diff == '0) ? IDLE : SETL;
            end
            SETL: begin
                if (r_cnt == 8'd0) begin
                    if (w_tgt_nxt == r_tap)
                        w_state_nxt = IDLE;
                    else if (!bus.freeze)
                        w_state_nxt = STEP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the settle counter.
    always_comb begin
        w_tap_nxt  = r_tap;
        w_cnt_nxt  = r_cnt;
        w_done_nxt = 1'b0;
        unique case (r_state)
            STEP: begin
                if (w_diff != '0) begin
                    w_tap_nxt = w_up ? r_tap + 1'b1 : r_tap - 1'b1;
                    w_cnt_nxt = CNT_LOAD;
                end
            end
            SETL: begin
                if (r_cnt != 8'd0)
                    w_cnt_nxt = r_cnt - 8'd1;
                else if (w_tgt_nxt == r_tap)
                    w_done_nxt = 1'b1;
            end
            default: ;
        endcase
        w_busy_nxt   = (w_state_nxt != IDLE) || (w_tgt_nxt != w_tap_nxt);
        w_onehot_nxt = NTAPS'(1) << w_tap_nxt;
    end

    // Datapath registers: target latch, tap select, decode, status.
    always_ff @(posedge clk40 or negedge rstn) begin
        if (!rstn) begin
            r_target <= '0;
            r_tap    <= '0;
            r_onehot <= NTAPS'(1);
            r_cnt    <= 8'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_target <= w_tgt_nxt;
            r_tap    <= w_tap_nxt;
            r_onehot <= w_onehot_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.tapSel    = r_tap;
    assign bus.tapOneHot = r_onehot;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_ps_tap_step_ctrl.sv
// Directed bench for ps_tap_step_ctrl: table of walks plus hand sequences
// for retarget, freeze, coincident load/settle and mid-walk reset.
module tb_ps_tap_step_ctrl;
    logic clk40 = 1'b0;
    logic rstn  = 1'b0;

    ps_tap_step_ctrl_if bus ();

    ps_tap_step_ctrl dut (
        .clk40 (clk40),
        .rstn  (rstn),
        .bus   (bus)
    );

    always #5 clk40 = ~clk40;

    typedef struct {
        logic [3:0] tgt;
        int         exp_done_at;
        int         exp_ndone;
        logic [3:0] exp_tap;
        int         exp_first;
        int         exp_busy0;
    } vec_t;

    vec_t vt [10];

    int n_vec = 0;
    int n_err = 0;

    int w_done_at;
    int w_ndone;
    int w_bad;
    int w_first;
    int w_busy0;

    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue a load, then watch budget cycles for steps, decode and done.
    task automatic walk(input logic [3:0] tgt, input int budget);
        logic [3:0] prev;
        logic [3:0] up1;
        logic [3:0] dn1;
        bus.load      = 1'b1;
        bus.targetTap = tgt;
        tick();
        bus.load  = 1'b0;
        w_busy0   = int'(bus.busy);
        w_done_at = -1;
        w_ndone   = 0;
        w_bad     = 0;
        w_first   = -1;
        prev      = bus.tapSel;
        for (int k = 1; k <= budget; k++) begin
            tick();
            up1 = prev + 4'd1;
            dn1 = prev - 4'd1;
            if (bus.tapSel != prev) begin
                if (w_first < 0) w_first = int'(bus.tapSel);
                if (bus.tapSel != up1 && bus.tapSel != dn1) w_bad++;
            end
            if (bus.tapOneHot != (16'd1 << bus.tapSel)) w_bad++;
            if (bus.done) begin
                w_ndone++;
                if (w_done_at < 0) w_done_at = k;
                if (bus.busy) w_bad++;
            end
            prev = bus.tapSel;
        end
    endtask

    initial begin
        int c;
        int t_first;
        int t_second;
        int nd;
        int bad;
        logic seen;

        vt[0] = '{4'd3,  28, 1, 4'd3,  1,  1};
        vt[1] = '{4'd2,  10, 1, 4'd2,  2,  1};
        vt[2] = '{4'd14, 37, 1, 4'd14, 1,  1};
        vt[3] = '{4'd6,  73, 1, 4'd6,  15, 1};
        vt[4] = '{4'd6,  -1, 0, 4'd6,  -1, 0};
        vt[5] = '{4'd0,  55, 1, 4'd0,  5,  1};
        vt[6] = '{4'd8,  73, 1, 4'd8,  1,  1};
        vt[7] = '{4'd7,  10, 1, 4'd7,  7,  1};
        vt[8] = '{4'd15, 73, 1, 4'd15, 8,  1};
        vt[9] = '{4'd1,  19, 1, 4'd1,  0,  1};

        bus.load      = 1'b0;
        bus.freeze    = 1'b0;
        bus.targetTap = 4'd0;
        tick();
        tick();
        chk("rst_tap",    int'(bus.tapSel),    0);
        chk("rst_onehot", int'(bus.tapOneHot), 1);
        chk("rst_busy",   int'(bus.busy),      0);
        chk("rst_done",   int'(bus.done),      0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            walk(vt[i].tgt, 90);
            chk($sformatf("v%0d_busy0", i),  w_busy0,   vt[i].exp_busy0);
            chk($sformatf("v%0d_doneat", i), w_done_at, vt[i].exp_done_at);
            chk($sformatf("v%0d_ndone", i),  w_ndone,   vt[i].exp_ndone);
            chk($sformatf("v%0d_first", i),  w_first,   vt[i].exp_first);
            chk($sformatf("v%0d_tap", i),    int'(bus.tapSel), int'(vt[i].exp_tap));
            chk($sformatf("v%0d_onehot", i), int'(bus.tapOneHot),
                int'(16'd1 << vt[i].exp_tap));
            chk($sformatf("v%0d_busy", i),   int'(bus.busy), 0);
            chk($sformatf("v%0d_bad", i),    w_bad, 0);
        end

        // Retarget mid-walk: 0 -> 7, at tap 3 request 1.
        walk(4'd0, 20);
        chk("ret_home", w_done_at, 10);
        bus.load      = 1'b1;
        bus.targetTap = 4'd7;
        tick();
        bus.load = 1'b0;
        seen = 1'b0;
        nd   = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (bus.done) nd++;
            if (bus.tapSel == 4'd3) seen = 1'b1;
        end
        chk("ret_reach3", int'(seen), 1);
        bus.load      = 1'b1;
        bus.targetTap = 4'd1;
        tick();
        bus.load  = 1'b0;
        c         = 1;
        t_first   = -1;
        t_second  = -1;
        w_done_at = -1;
        bad       = 0;
        for (int k = 2; k <= 60; k++) begin
            tick();
            if (bus.tapSel == 4'd2 && t_first < 0)  t_first = k;
            if (bus.tapSel == 4'd1 && t_second < 0) t_second = k;
            if (bus.tapSel > 4'd3) bad++;
            if (bus.done) begin
                nd++;
                if (w_done_at < 0) w_done_at = k;
            end
        end
        chk("ret_to2",    t_first,   9);
        chk("ret_to1",    t_second,  18);
        chk("ret_doneat", w_done_at, 26);
        chk("ret_ndone",  nd,        1);
        chk("ret_path",   bad,       0);
        chk("ret_tap",    int'(bus.tapSel), 1);

        // Freeze held in IDLE with a pending target, then released.
        walk(4'd0, 20);
        chk("frz_home", w_done_at, 10);
        bus.freeze    = 1'b1;
        bus.load      = 1'b1;
        bus.targetTap = 4'd5;
        tick();
        bus.load = 1'b0;
        chk("frz_busy0", int'(bus.busy), 1);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bus.tapSel != 4'd0 || !bus.busy || bus.done) bad++;
        end
        chk("frz_hold", bad, 0);
        bus.freeze = 1'b0;
        w_done_at  = -1;
        nd         = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (bus.done) begin
                nd++;
                if (w_done_at < 0) w_done_at = k;
            end
        end
        chk("frz_doneat", w_done_at, 46);
        chk("frz_ndone",  nd,        1);
        chk("frz_tap",    int'(bus.tapSel), 5);

        // Load landing on the settle-complete edge, equal to current tap.
        bus.load      = 1'b1;
        bus.targetTap = 4'd7;
        tick();
        bus.load = 1'b0;
        nd = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (bus.done) nd++;
        end
        chk("coin_tap6", int'(bus.tapSel), 6);
        bus.load      = 1'b1;
        bus.targetTap = 4'd6;
        tick();
        bus.load = 1'b0;
        chk("coin_done", int'(bus.done), 1);
        chk("coin_busy", int'(bus.busy), 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.done) nd++;
        end
        chk("coin_ndone", nd, 0);
        chk("coin_tap",   int'(bus.tapSel), 6);

        // Reset asserted mid-walk.
        bus.load      = 1'b1;
        bus.targetTap = 4'd12;
        tick();
        bus.load = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (bus.tapSel == 4'd9) seen = 1'b1;
        end
        chk("rw_reach9", int'(seen), 1);
        rstn = 1'b0;
        #1;
        chk("rw_tap",    int'(bus.tapSel),    0);
        chk("rw_onehot", int'(bus.tapOneHot), 1);
        chk("rw_busy",   int'(bus.busy),      0);
        chk("rw_done",   int'(bus.done),      0);
        tick();
        tick();
        rstn = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.done) nd++;
            if (bus.tapSel != 4'd0) nd++;
        end
        chk("rw_quiet", nd, 0);
        walk(4'd0, 20);
        chk("rw_ld0_busy0", w_busy0, 0);
        chk("rw_ld0_ndone", w_ndone, 0);
        chk("rw_ld0_busy",  int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
